scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
- Parametrised, registered N-channel W-bit multiplexer with two modes: manual (select-driven) and auto-scan (round-robin channel sweep with programmable dwell).
- Output is a registered sample with channel tag and valid/ready handshake, so it can feed sequential consumers (serialisers, loggers) in the mux family of blocks.
- Generalises the 8:1 single-bit combinational mux in channel count, data width, sequencing and flow control.

Parameters:
- N_CH, 8, number of input channels (>=2).
- W, 1, data width per channel in bits.
- DWELL, 4, cycles spent on each channel in auto-scan before sampling (>=1).
- SELW (localparam), $clog2(N_CH), width of select and channel tag.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  N_CH*W  packed channels; channel k occupies bits [k*W +: W].
- sel  input  SELW  manual-mode channel select; auto-scan start channel.
- mode  input  1  0 = manual, 1 = auto-scan.
- en  input  1  block enable.
- out  output  W  registered sampled data.
- out_ch  output  SELW  channel index that produced out.
- out_valid  output  1  out/out_ch hold a sample not yet accepted.
- out_ready  input  1  consumer accepts the sample when high with out_valid.
- sel_err  output  1  one-cycle pulse: manual sample attempted with sel >= N_CH.

Behaviour:
- Reset (rst=1 at a clk edge, overrides all): out=0, out_ch=0, out_valid=0, sel_err=0, ptr=0, dwell count=0, state=IDLE. Reset mid-scan discards the pending sample.
- Handshake: transfer occurs on a cycle with out_valid=1 and out_ready=1. A new sample may be loaded on a cycle when out_valid=0 or a transfer occurs ("slot free"). out/out_ch stay stable while out_valid=1 and out_ready=0.
- out_valid clears the cycle after a transfer unless a new sample is loaded that same cycle.
- FSM states: IDLE, MANUAL, SCAN.
  - IDLE: en=0. No new samples. A pending sample remains valid until accepted. en=1 & mode=0 -> MANUAL. en=1 & mode=1 -> SCAN, with ptr<=sel (ptr<=0 if sel>=N_CH) and dwell count<=0.
  - MANUAL: each cycle with slot free, out<=in[sel], out_ch<=sel, out_valid<=1. Latency is one cycle from sel/in to out.
    - If sel>=N_CH: out<=0, out_ch<=sel, out_valid<=1, sel_err pulses.
    - en=0 -> IDLE. mode=1 -> SCAN, loading ptr from sel as in IDLE.
  - SCAN: dwell count increments 0..DWELL-1.
    - At DWELL-1 with slot free: out<=in[ptr], out_ch<=ptr, out_valid<=1, count<=0, ptr<=ptr+1, wrapping N_CH-1 -> 0 (for non-power-of-2 N_CH also).
    - At DWELL-1 with slot not free (backpressure): count holds at DWELL-1 and ptr holds. No sample is overwritten or skipped.
    - en=0 -> IDLE. mode=0 -> MANUAL; count is reset.
    - DWELL=1: one sample per cycle under continuous ready.
- sel_err is never asserted in SCAN or IDLE.
- Input data is sampled at the loading edge, not at dwell start.

Decomposition:
- Shared package mux_pkg holds:
  - the state enum (IDLE, MANUAL, SCAN) and mode encodings (MODE_MANUAL=0, MODE_SCAN=1);
  - a clog2-safe select-width function.
- Sub-module scan_ptr: the wrap-around channel pointer plus dwell counter, with load, advance and stall inputs and a "sample now" output.
- Data slicing and the output register stay in scan_mux.

Test Plan:
- Reset: assert rst for 2 cycles mid-SCAN with out_valid=1 -> next cycle out=0, out_ch=0, out_valid=0; no sample for DWELL cycles after re-entering SCAN.
- Manual, N_CH=8, W=1, out_ready=1, in=8'b01100110, sel=0..7 one per cycle -> out one cycle later = 0,1,1,0,0,1,1,0 with out_ch matching sel.
- Auto-scan, DWELL=2, out_ready=1, sel=0, in=8'b01100110 -> a sample every 2 cycles: out = 0,1,1,0,0,1,1,0, then channel 0 again (out_ch 7 -> 0 wrap).
- Backpressure: SCAN with out_ready=0 for 5 cycles after the first sample -> out/out_ch frozen at ch0. Raising out_ready yields ch1 next; no channel is skipped.
- Out-of-range, N_CH=6, SELW=3, manual sel=7 -> out=0, out_ch=7, out_valid=1, sel_err one-cycle pulse. Switching to SCAN with sel=7 starts at ch0.
- Wide data, N_CH=4, W=8, in={8'hDD,8'hCC,8'hBB,8'hAA}, auto DWELL=1 -> out = AA, BB, CC, DD, AA on consecutive cycles.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the mux family of blocks.
//   state_e     : sequencing states of scan_mux (IDLE, MANUAL, SCAN)
//   MODE_*      : encodings of the mode input
//   sel_width() : select/tag width for a channel count, never less than 1 bit
// -----------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // $clog2(1) is 0, which would give a zero-width vector.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// -----------------------------------------------------------------------------
// scan_mux_if
// Bundle of the scan_mux data/control inputs and the sampled-output handshake.
//   in        : N_CH*W packed channels, channel k at [k*W +: W]
//   sel       : manual select / auto-scan start channel
//   mode, en  : mode (MODE_MANUAL/MODE_SCAN) and block enable
//   out       : registered sample, out_ch its channel tag
//   out_valid : sample pending, out_ready : consumer accepts
//   sel_err   : one-cycle pulse on an out-of-range manual sample
// Modports: master drives the inputs and consumes samples, slave is the mux.
// -----------------------------------------------------------------------------
interface scan_mux_if
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 1
);
  localparam int SELW = sel_width(N_CH);

  logic [N_CH*W-1:0] in;
  logic [SELW-1:0]   sel;
  logic              mode;
  logic              en;
  logic [W-1:0]      out;
  logic [SELW-1:0]   out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              sel_err;

  modport master (
    output in, sel, mode, en, out_ready,
    input  out, out_ch, out_valid, sel_err
  );

  modport slave (
    input  in, sel, mode, en, out_ready,
    output out, out_ch, out_valid, sel_err
  );

endinterface

// File: rtl/scan_ptr.sv
// -----------------------------------------------------------------------------
// scan_ptr
// Wrap-around channel pointer plus dwell counter for the auto-scan sweep.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : restart the sweep at load_val_i (channel 0 if out of range)
//   clear_i    : zero the dwell count, pointer kept
//   advance_i  : sweep active this cycle (count runs)
//   stall_i    : output slot busy; hold at the last dwell cycle
//   ptr_o      : channel currently being dwelt on
//   sample_o   : last dwell cycle reached while active; sample ptr_o now
// -----------------------------------------------------------------------------
module scan_ptr
  import mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int DWELL = 4,
  localparam int SELW  = sel_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SELW-1:0] load_val_i,
  input  logic            clear_i,
  input  logic            advance_i,
  input  logic            stall_i,
  output logic [SELW-1:0] ptr_o,
  output logic            sample_o
);

  localparam int              CW       = sel_width(DWELL);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [SELW-1:0] PTR_LAST = SELW'(N_CH - 1);
  localparam logic [SELW:0]   N_CH_X   = (SELW + 1)'(N_CH);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign ptr_o    = ptr_q;
  assign sample_o = advance_i && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      ptr_d = ({1'b0, load_val_i} < N_CH_X) ? load_val_i : '0;
      cnt_d = '0;
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (advance_i) begin
      if (cnt_q == CNT_LAST) begin
        // Under backpressure both count and pointer freeze, so the channel
        // is sampled late rather than skipped.
        if (!stall_i) begin
          cnt_d = '0;
          ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
// Registered N_CH-channel, W-bit multiplexer with manual (select-driven) and
// auto-scan (round-robin, DWELL cycles per channel) modes. The output is a
// tagged sample held under a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : scan_mux_if.slave (in, sel, mode, en, out_ready in;
//              out, out_ch, out_valid, sel_err out)
// -----------------------------------------------------------------------------
module scan_mux
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input logic        clk,
  input logic        rst,
  scan_mux_if.slave  bus
);

  localparam int            SELW   = sel_width(N_CH);
  localparam logic [SELW:0] N_CH_X = (SELW + 1)'(N_CH);

  state_e          state_q;
  logic [W-1:0]    out_q;
  logic [SELW-1:0] out_ch_q;
  logic            out_valid_q;
  logic            sel_err_q;

  logic            transfer, slot_free, want_scan, sel_ok;
  logic            scan_load, scan_clear, scan_adv, sample_now;
  logic [SELW-1:0] ptr;

  // Returns zero for an index with no matching channel.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] v,
                                        input logic [SELW-1:0]   idx);
    pick = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SELW'(k)) pick = v[k*W +: W];
    end
  endfunction

  assign transfer  = out_valid_q && bus.out_ready;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign want_scan = bus.en && (bus.mode == MODE_SCAN);
  assign sel_ok    = ({1'b0, bus.sel} < N_CH_X);

  assign scan_load  = want_scan && (state_q != SCAN);
  assign scan_adv   = want_scan && (state_q == SCAN);
  assign scan_clear = bus.en && (bus.mode == MODE_MANUAL) && (state_q == SCAN);

  scan_ptr #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (scan_load),
    .load_val_i (bus.sel),
    .clear_i    (scan_clear),
    .advance_i  (scan_adv),
    .stall_i    (!slot_free),
    .ptr_o      (ptr),
    .sample_o   (sample_now)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      // A load below in the same cycle overrides this clear.
      if (transfer) out_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.en) state_q <= want_scan ? SCAN : MANUAL;
        end
        MANUAL: begin
          if (!bus.en) begin
            state_q <= IDLE;
          end else if (want_scan) begin
            state_q <= SCAN;
          end else if (slot_free) begin
            out_q       <= pick(bus.in, bus.sel);
            out_ch_q    <= bus.sel;
            out_valid_q <= 1'b1;
            sel_err_q   <= !sel_ok;
          end
        end
        SCAN: begin
          if (!bus.en) begin
            state_q <= IDLE;
          end else if (!want_scan) begin
            state_q <= MANUAL;
          end else if (sample_now && slot_free) begin
            out_q       <= pick(bus.in, ptr);
            out_ch_q    <= ptr;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_mux
// Three scan_mux instances cover the configurations of interest:
//   a : N_CH=8, W=1, DWELL=2   manual sweep, auto-scan wrap, backpressure, reset
//   b : N_CH=6, W=1, DWELL=3   out-of-range select, non-power-of-2 wrap
//   c : N_CH=4, W=8, DWELL=1   wide data, one sample per cycle
// Stimulus pushes expected samples into per-instance queues; monitors pop and
// compare on every accepted transfer.
// -----------------------------------------------------------------------------
module tb_scan_mux;
  import mux_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_mux_if #(.N_CH(8), .W(1)) ifa ();
  scan_mux_if #(.N_CH(6), .W(1)) ifb ();
  scan_mux_if #(.N_CH(4), .W(8)) ifc ();

  scan_mux #(.N_CH(8), .W(1), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  scan_mux #(.N_CH(6), .W(1), .DWELL(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  scan_mux #(.N_CH(4), .W(8), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // Hand-computed tables.
  // in=8'b01100110 read from channel 0 upward.
  int man_a[8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
  // in=6'b101100, sweep from channel 0 through 5 and wrapping to 0.
  int scan_b[7] = '{0, 0, 1, 1, 0, 1, 0};
  int wide_c[5] = '{'hAA, 'hBB, 'hCC, 'hDD, 'hAA};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int d, input int c);
    exp_t e;
    e.data = 8'(d);
    e.ch   = 3'(c);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer happens at the next rising edge whenever valid and
  // ready are both high here.
  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      if (q_a.size() == 0) check("a_unexpected_sample", 32'(ifa.out_ch), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_data", 32'(ifa.out), 32'(e.data));
        check("a_ch",   32'(ifa.out_ch), 32'(e.ch));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (q_b.size() == 0) check("b_unexpected_sample", 32'(ifb.out_ch), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_data", 32'(ifb.out), 32'(e.data));
        check("b_ch",   32'(ifb.out_ch), 32'(e.ch));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (q_c.size() == 0) check("c_unexpected_sample", 32'(ifc.out_ch), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q_c.pop_front();
        check("c_data", 32'(ifc.out), 32'(e.data));
        check("c_ch",   32'(ifc.out_ch), 32'(e.ch));
      end
    end
  end

  initial begin
    logic serr_seen;

    ifa.in = 8'b01100110; ifa.sel = '0; ifa.mode = MODE_MANUAL; ifa.en = 1'b0; ifa.out_ready = 1'b0;
    ifb.in = 6'b101100;   ifb.sel = '0; ifb.mode = MODE_MANUAL; ifb.en = 1'b0; ifb.out_ready = 1'b0;
    ifc.in = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    ifc.sel = '0; ifc.mode = MODE_MANUAL; ifc.en = 1'b0; ifc.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_a_out",       32'(ifa.out), 0);
    check("rst_a_out_ch",    32'(ifa.out_ch), 0);
    check("rst_a_out_valid", 32'(ifa.out_valid), 0);
    check("rst_a_sel_err",   32'(ifa.sel_err), 0);
    check("rst_b_out_valid", 32'(ifb.out_valid), 0);
    check("rst_c_out_valid", 32'(ifc.out_valid), 0);

    // Manual sweep on a: one select per cycle, sample one cycle later
    ifa.en = 1'b1; ifa.mode = MODE_MANUAL; ifa.sel = '0; ifa.out_ready = 1'b1;
    tick();                                   // IDLE -> MANUAL
    for (int s = 0; s < 8; s++) begin
      ifa.sel = 3'(s);
      q_a.push_back(mk(man_a[s], s));
      tick();
      check("man_a_out_ch", 32'(ifa.out_ch), 32'(s));
    end
    ifa.en = 1'b0;
    tick();
    check("man_a_idle_valid", 32'(ifa.out_valid), 0);

    // Auto-scan on a, DWELL=2: ch0..ch7 then ch0 again
    for (int k = 0; k < 9; k++) q_a.push_back(mk(man_a[k % 8], k % 8));
    ifa.mode = MODE_SCAN; ifa.sel = '0; ifa.en = 1'b1;
    tick();                                   // enter SCAN, ptr=0
    tick();
    check("scan_a_dwell_valid", 32'(ifa.out_valid), 0);
    tick();
    check("scan_a_first_valid", 32'(ifa.out_valid), 1);
    check("scan_a_first_ch",    32'(ifa.out_ch), 0);
    repeat (16) tick();
    ifa.en = 1'b0;
    tick();
    check("scan_a_end_valid", 32'(ifa.out_valid), 0);
    check("scan_a_queue_drained", 32'(q_a.size()), 0);

    // Backpressure on a: hold ch0 for 5 cycles, then ch1 follows
    q_a.push_back(mk(man_a[0], 0));
    q_a.push_back(mk(man_a[1], 1));
    ifa.sel = '0; ifa.en = 1'b1;
    tick(); tick(); tick();                   // ch0 loaded
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_a_hold_valid", 32'(ifa.out_valid), 1);
      check("bp_a_hold_ch",    32'(ifa.out_ch), 0);
      check("bp_a_hold_out",   32'(ifa.out), 32'(man_a[0]));
    end
    ifa.out_ready = 1'b1;
    tick();
    check("bp_a_next_ch",    32'(ifa.out_ch), 1);
    check("bp_a_next_valid", 32'(ifa.out_valid), 1);
    ifa.en = 1'b0;
    tick();

    // Reset mid-scan on a with a pending sample
    ifa.sel = 3'd3; ifa.en = 1'b1; ifa.out_ready = 1'b0;
    tick(); tick();
    q_a.push_back(mk(man_a[3], 3));
    tick();
    check("rs_a_pending_valid", 32'(ifa.out_valid), 1);
    check("rs_a_pending_ch",    32'(ifa.out_ch), 3);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    void'(q_a.pop_back());                    // the pending sample is discarded
    check("rs_a_out",       32'(ifa.out), 0);
    check("rs_a_out_ch",    32'(ifa.out_ch), 0);
    check("rs_a_out_valid", 32'(ifa.out_valid), 0);
    tick();                                   // IDLE -> SCAN
    check("rs_a_dwell0_valid", 32'(ifa.out_valid), 0);
    tick();
    check("rs_a_dwell1_valid", 32'(ifa.out_valid), 0);
    q_a.push_back(mk(man_a[3], 3));
    tick();
    check("rs_a_resume_valid", 32'(ifa.out_valid), 1);
    check("rs_a_resume_ch",    32'(ifa.out_ch), 3);
    ifa.out_ready = 1'b1; ifa.en = 1'b0;
    tick();

    // Out-of-range manual select on b (N_CH=6, sel=7)
    ifb.en = 1'b1; ifb.mode = MODE_MANUAL; ifb.sel = 3'd7; ifb.out_ready = 1'b0;
    tick();                                   // IDLE -> MANUAL
    check("oor_b_pre_sel_err", 32'(ifb.sel_err), 0);
    q_b.push_back(mk(0, 7));
    tick();
    check("oor_b_sel_err",   32'(ifb.sel_err), 1);
    check("oor_b_out",       32'(ifb.out), 0);
    check("oor_b_out_ch",    32'(ifb.out_ch), 7);
    check("oor_b_out_valid", 32'(ifb.out_valid), 1);
    tick();
    check("oor_b_sel_err_pulse", 32'(ifb.sel_err), 0);
    check("oor_b_held_ch",       32'(ifb.out_ch), 7);

    // Switch b to SCAN with sel=7: sweep starts at ch0 and wraps 5 -> 0
    for (int k = 0; k < 7; k++) q_b.push_back(mk(scan_b[k], k % 6));
    ifb.mode = MODE_SCAN; ifb.out_ready = 1'b1;
    serr_seen = 1'b0;
    repeat (22) begin
      tick();
      serr_seen |= ifb.sel_err;
    end
    ifb.en = 1'b0;
    tick();
    check("scan_b_no_sel_err", 32'(serr_seen), 0);
    check("scan_b_end_valid",  32'(ifb.out_valid), 0);

    // Wide data on c, DWELL=1: one sample per cycle
    for (int k = 0; k < 5; k++) q_c.push_back(mk(wide_c[k], k % 4));
    ifc.en = 1'b1; ifc.mode = MODE_SCAN; ifc.sel = '0; ifc.out_ready = 1'b1;
    tick();                                   // enter SCAN
    check("wide_c_start_valid", 32'(ifc.out_valid), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("wide_c_valid", 32'(ifc.out_valid), 1);
      check("wide_c_out",   32'(ifc.out), 32'(wide_c[k]));
    end
    ifc.en = 1'b0;
    tick();

    // Bounded drain of anything still expected
    for (int i = 0; i < 20; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
      tick();
    end
    check("final_q_a_empty", 32'(q_a.size()), 0);
    check("final_q_b_empty", 32'(q_b.size()), 0);
    check("final_q_c_empty", 32'(q_c.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
